// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one byte per ready/valid handshake, LSB first,
// 8N1 framing at CLOCK_FREQ / BAUD_RATE clock cycles per bit.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the data bits and the stop bit (11-bit frames instead of 10).
module uart_transmitter #(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int unsigned SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] CNT_LAST =
        CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
    // Ready goes high one cycle early so a held valid lands on the stop bit's last cycle.
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] CNT_PRE_LAST =
        CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                         state_q, state_d;
    logic [CLOCK_COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]                     bit_idx_q, bit_idx_d;
    logic [7:0]                     shift_q, shift_d;
    logic                           serial_q, serial_d;
    logic                           ready_q, ready_d;
`ifdef UART_TX_PARITY_EN
    logic                           parity_q, parity_d;
`endif
    logic                           hs_c;
    logic                           last_c;

    assign hs_c   = data_in_valid && ready_q;
    assign last_c = (cnt_q == CNT_LAST);

    // Next-state and registered-output logic; a handshake overrides everything.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        ready_d   = ready_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        if (state_q != IDLE) begin
            cnt_d = last_c ? '0 : cnt_q + CLOCK_COUNTER_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
                ready_d  = 1'b1;
            end
            START: begin
                if (last_c) begin
                    state_d  = DATA;
                    serial_d = shift_q[0];
                end
            end
            DATA: begin
                if (last_c) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        serial_d  = parity_q;
`else
                        state_d   = STOP;
                        serial_d  = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        serial_d  = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (last_c) begin
                    state_d  = STOP;
                    serial_d = 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_PRE_LAST) begin
                    ready_d = 1'b1;
                end
                if (last_c) begin
                    state_d  = IDLE;
                    serial_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                serial_d = 1'b1;
            end
        endcase

        if (hs_c) begin
            state_d   = START;
            cnt_d     = '0;
            bit_idx_d = 3'd0;
            shift_d   = data_in;
            serial_d  = 1'b0;
            ready_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^data_in;
`endif
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            serial_q  <= 1'b1;
            ready_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            ready_q   <= ready_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign serial_out    = serial_q;
    assign data_in_ready = ready_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a per-cycle line model built from
// frame bit lists is compared against serial_out and data_in_ready each cycle.
module tb_uart_transmitter;

    localparam int unsigned SET = 10;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Expected line level per upcoming cycle; front entry is the current cycle.
    bit   exp_q[$];
    logic exp_serial = 1'b1;
    logic exp_ready  = 1'b0;

    uart_transmitter #(
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame = start, 8 data bits LSB first, optional even parity, stop; each SET cycles.
    function automatic void push_frame(input logic [7:0] b);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int k = 0; k < int'(SET); k++) exp_q.push_back(bits[i]);
        end
    endfunction

    // Advance the model by one posedge using the inputs present at that edge.
    function automatic void model_step();
        logic hs;
        if (!rst) begin
            exp_q.delete();
            exp_serial = 1'b1;
            exp_ready  = 1'b0;
        end else begin
            hs = data_in_valid && exp_ready;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (hs) push_frame(data_in);
            exp_serial = (exp_q.size() > 0) ? logic'(exp_q[0]) : 1'b1;
            exp_ready  = (exp_q.size() <= 1);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_eq("serial_out", 32'(serial_out), 32'(exp_serial));
        check_eq("data_in_ready", 32'(data_in_ready), 32'(exp_ready));
    endtask

    task automatic wait_ready();
        int budget = 300;
        while (!exp_ready && budget > 0) begin
            tick();
            budget--;
        end
        check_eq("ready_wait", 32'(data_in_ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready();
        data_in       = b;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] seen;
        int         lat;

        // Reset held with valid asserted: line stays idle, not ready.
        rst = 1'b0;
        data_in = 8'h55;
        data_in_valid = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        data_in_valid = 1'b0;
        tick();
        check_eq("ready_after_reset", 32'(data_in_ready), 32'd1);
        repeat (8) tick();
        check_eq("idle_line", 32'(serial_out), 32'd1);

        // Single byte 0xA5 sampled mid-bit against the literal waveform.
        send_byte(8'hA5);
        seen = '0;
        for (int c = 1; c <= int'(FRAME_BITS * SET); c++) begin
            if (((c - 1) % int'(SET)) == int'(SET / 2) && ((c - 1) / int'(SET)) < 9)
                seen[(c - 1) / int'(SET)] = serial_out;
            if (c < int'(FRAME_BITS * SET)) tick();
        end
        check_eq("a5_bits", 32'(seen), 32'h14A);
        repeat (5) tick();

        // Back-to-back 0x00 then 0xFF with valid held high.
        wait_ready();
        data_in       = 8'h00;
        data_in_valid = 1'b1;
        tick();
        data_in = 8'hFF;
        lat = 0;
        while (!data_in_ready && lat < 200) begin
            tick();
            lat++;
        end
        check_eq("ready_latency", 32'(lat), 32'(FRAME_BITS * SET - 1));
        tick();
        data_in_valid = 1'b0;
        repeat (FRAME_BITS * SET + 5) tick();

        // Data changes mid-frame are ignored; valid stays up for a follow-on byte.
        send_byte(8'h81);
        data_in_valid = 1'b1;
        repeat (34) tick();
        data_in = 8'h3C;
        repeat (70) tick();
        data_in_valid = 1'b0;
        repeat (FRAME_BITS * SET + 5) tick();

        // Reset mid-frame abandons the byte; next frame is clean.
        send_byte(8'h5A);
        repeat (46) tick();
        rst = 1'b0;
        tick();
        check_eq("reset_midframe_line", 32'(serial_out), 32'd1);
        tick();
        rst = 1'b1;
        send_byte(8'hC3);
        repeat (FRAME_BITS * SET + 5) tick();

`ifdef UART_TX_PARITY_EN
        send_byte(8'h07);
        repeat (FRAME_BITS * SET + 2) tick();
        send_byte(8'h03);
        repeat (FRAME_BITS * SET + 2) tick();
`endif

        // Randomised traffic with occasional held valid, data churn and resets.
        for (int it = 0; it < 40; it++) begin
            int gap;
            gap = int'($urandom_range(0, 12));
            for (int g = 0; g < gap; g++) begin
                data_in = 8'($urandom);
                tick();
            end
            send_byte(8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                data_in_valid = 1'b1;
                data_in = 8'($urandom);
            end
            gap = int'($urandom_range(0, 130));
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 9) == 0) data_in = 8'($urandom);
                tick();
            end
            data_in_valid = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b0;
                data_in_valid = 1'($urandom_range(0, 1));
                repeat (2) tick();
                rst = 1'b1;
                data_in_valid = 1'b0;
            end
        end
        repeat (FRAME_BITS * SET * 2 + 5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
